conv_layer_sched: RTL and testbench

Layer-level scheduler sitting above the MAC-array controller and the psum drain unit. It accepts a multi-layer run request and sequences each layer through three phases: weight load, convolution and psum drain. Psum uses ping-pong banks, so the drain of layer k overlaps the weight load and convolution of layer k+1. It raises a single-cycle completion pulse when the last drain finishes.

---
 rtl/conv_layer_sched_pkg.sv | 22 ++
 rtl/psum_drain_tracker.sv | 80 ++++++++
 rtl/conv_layer_sched.sv | 153 +++++++++++++++
 tb/tb_conv_layer_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sched_pkg.sv
// Shared types and defaults for the layer scheduler.
package conv_layer_sched_pkg;

  localparam int unsigned LayerWDefault = 4;
  localparam int unsigned PerfWDefault  = 32;

  // Main FSM state encoding
  localparam logic [2:0] StateIdle     = 3'd0;
  localparam logic [2:0] StateWload    = 3'd1;
  localparam logic [2:0] StateConvWait = 3'd2;
  localparam logic [2:0] StateConvRun  = 3'd3;
  localparam logic [2:0] StateFlush    = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = StateIdle,
    StWload    = StateWload,
    StConvWait = StateConvWait,
    StConvRun  = StateConvRun,
    StFlush    = StateFlush
  } state_e;

endpackage

// File: rtl/psum_drain_tracker.sv
// Tracks which psum banks await draining and launches drains in strict FIFO order.
module psum_drain_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       set_pend,
  input  logic       set_bank,
  input  logic       drain_done,
  output logic       drain_start,
  output logic       drain_bank,
  output logic [1:0] bank_busy,
  output logic       quiet
);

  logic [1:0] pend_q, pend_d;
  logic       draining_q, draining_d;
  logic       oldest_q, oldest_d;
  logic       start_q, start_d;
  logic       bank_q, bank_d;
  logic       launch;
  logic       launch_bank;

  // Next-state: retire finished drain, launch the oldest pending bank, record new pending bank
  always_comb begin
    pend_d      = pend_q;
    draining_d  = draining_q;
    oldest_d    = oldest_q;
    start_d     = 1'b0;
    bank_d      = bank_q;
    launch      = !draining_q && (pend_q != 2'b00);
    // With both banks pending the older one goes first
    launch_bank = (pend_q == 2'b11) ? oldest_q : pend_q[1];

    if (draining_q && drain_done) begin
      draining_d = 1'b0;
    end
    if (launch) begin
      pend_d[launch_bank] = 1'b0;
      draining_d          = 1'b1;
      start_d             = 1'b1;
      bank_d              = launch_bank;
    end
    if (set_pend) begin
      pend_d[set_bank] = 1'b1;
      if (pend_d[!set_bank]) begin
        oldest_d = !set_bank;
      end
    end
    if (clear) begin
      pend_d     = 2'b00;
      draining_d = 1'b0;
      start_d    = 1'b0;
    end
  end

  // Tracker state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 2'b00;
      draining_q <= 1'b0;
      oldest_q   <= 1'b0;
      start_q    <= 1'b0;
      bank_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      draining_q <= draining_d;
      oldest_q   <= oldest_d;
      start_q    <= start_d;
      bank_q     <= bank_d;
    end
  end

  assign drain_start  = start_q;
  assign drain_bank   = bank_q;
  assign bank_busy[0] = pend_q[0] | (draining_q & ~bank_q);
  assign bank_busy[1] = pend_q[1] | (draining_q & bank_q);
  // Finishing drain counts as quiet so completion is reported the cycle after drain_done
  assign quiet        = (pend_q == 2'b00) && (!draining_q || drain_done);

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: sequences weight load, conv and ping-pong psum drain per layer.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int unsigned LAYER_W = LayerWDefault,
  parameter int unsigned PERF_W  = PerfWDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_start,
  input  logic [LAYER_W-1:0] host_layers,
  input  logic               abort,
  output logic               busy,
  output logic               all_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               wload_start,
  input  logic               wload_done,
  output logic               conv_start,
  input  logic               conv_done,
  output logic               conv_bank,
  output logic               drain_start,
  output logic               drain_bank,
  input  logic               drain_done,
  output logic [PERF_W-1:0]  conv_cycles
);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] last_q, last_d;
  logic [PERF_W-1:0]  cyc_q, cyc_d;
  logic               busy_q, busy_d;
  logic               all_done_q, all_done_d;
  logic               wload_start_q, wload_start_d;
  logic               conv_start_q, conv_start_d;
  logic               set_pend;
  logic [1:0]         bank_busy;
  logic               quiet;

  // Next-state and registered-output decode; abort overrides everything
  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    last_d        = last_q;
    cyc_d         = cyc_q;
    busy_d        = busy_q;
    all_done_d    = 1'b0;
    wload_start_d = 1'b0;
    conv_start_d  = 1'b0;
    set_pend      = 1'b0;

    if ((state_q == StConvRun) && (cyc_q != '1)) begin
      cyc_d = cyc_q + PERF_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (host_start && (host_layers != '0)) begin
          state_d       = StWload;
          layer_d       = '0;
          last_d        = host_layers - LAYER_W'(1);
          cyc_d         = '0;
          busy_d        = 1'b1;
          wload_start_d = 1'b1;
        end
      end
      StWload: begin
        if (wload_done) state_d = StConvWait;
      end
      StConvWait: begin
        if (!bank_busy[layer_q[0]]) begin
          state_d      = StConvRun;
          conv_start_d = 1'b1;
        end
      end
      StConvRun: begin
        if (conv_done) begin
          set_pend = 1'b1;
          if (layer_q == last_q) begin
            state_d = StFlush;
          end else begin
            layer_d       = layer_q + LAYER_W'(1);
            state_d       = StWload;
            wload_start_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (quiet) begin
          state_d    = StIdle;
          busy_d     = 1'b0;
          all_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d       = StIdle;
      layer_d       = '0;
      cyc_d         = cyc_q;
      busy_d        = 1'b0;
      all_done_d    = 1'b0;
      wload_start_d = 1'b0;
      conv_start_d  = 1'b0;
      set_pend      = 1'b0;
    end
  end

  // FSM, layer counter and perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      layer_q       <= '0;
      last_q        <= '0;
      cyc_q         <= '0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      wload_start_q <= 1'b0;
      conv_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      last_q        <= last_d;
      cyc_q         <= cyc_d;
      busy_q        <= busy_d;
      all_done_q    <= all_done_d;
      wload_start_q <= wload_start_d;
      conv_start_q  <= conv_start_d;
    end
  end

  psum_drain_tracker u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (abort),
    .set_pend   (set_pend),
    .set_bank   (layer_q[0]),
    .drain_done (drain_done),
    .drain_start(drain_start),
    .drain_bank (drain_bank),
    .bank_busy  (bank_busy),
    .quiet      (quiet)
  );

  assign busy        = busy_q;
  assign all_done    = all_done_q;
  assign layer_idx   = layer_q;
  assign wload_start = wload_start_q;
  assign conv_start  = conv_start_q;
  assign conv_bank   = layer_q[0];
  assign conv_cycles = cyc_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench: cycle model of the scheduling rules plus directed literal checks.
module tb_conv_layer_sched;

  localparam int LW = 4;
  localparam int PW = 6;
  localparam int unsigned CMAX = (1 << PW) - 1;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_BANKWAIT = 2, PH_CONV = 3, PH_FLUSH = 4;
  localparam int O_WL = 0, O_CS = 1, O_DS = 2;

  logic clk = 1'b0;
  logic rst, host_start, abort, wload_done, conv_done, drain_done;
  logic [LW-1:0] host_layers;
  logic busy, all_done, wload_start, conv_start, conv_bank, drain_start, drain_bank;
  logic [LW-1:0] layer_idx;
  logic [PW-1:0] conv_cycles;

  conv_layer_sched #(.LAYER_W(LW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .host_start(host_start), .host_layers(host_layers), .abort(abort),
    .busy(busy), .all_done(all_done), .layer_idx(layer_idx), .wload_start(wload_start),
    .wload_done(wload_done), .conv_start(conv_start), .conv_done(conv_done),
    .conv_bank(conv_bank), .drain_start(drain_start), .drain_bank(drain_bank),
    .drain_done(drain_done), .conv_cycles(conv_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cycle = 0;

  // Reference model state
  int ph = PH_IDLE, m_layer = 0, m_last = 0;
  int unsigned m_cyc = 0;
  bit m_busy = 0, e_all = 0, e_wl = 0, e_cs = 0, e_ds = 0, m_draining = 0, m_dbank = 0;
  int pq[$];

  // Responders and logs
  bit auto_resp = 1, noise = 0;
  int dw = 5, dc = 5, dd = 5, wl_cnt = 0, cv_cnt = 0, dr_cnt = 0;
  int wl_cyc[$], cs_cyc[$], cd_cyc[$], dd_cyc[$], ad_cyc[$], cs_bank[$], ds_bank[$];
  int n_wl = 0, n_cs = 0, n_ds = 0, n_ad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock of the scheduling rules, using this cycle's inputs
  task automatic model_step();
    bit free, quiet;
    if (rst) begin
      ph = PH_IDLE; m_layer = 0; m_last = 0; m_cyc = 0; m_busy = 0;
      e_all = 0; e_wl = 0; e_cs = 0; e_ds = 0; pq.delete(); m_draining = 0; m_dbank = 0;
    end else if (abort) begin
      ph = PH_IDLE; m_layer = 0; m_busy = 0;
      e_all = 0; e_wl = 0; e_cs = 0; e_ds = 0; pq.delete(); m_draining = 0;
    end else begin
      free = !(m_draining && (m_dbank == (m_layer % 2)));
      foreach (pq[i]) if (pq[i] == m_layer % 2) free = 0;
      quiet = (pq.size() == 0) && (!m_draining || drain_done);
      e_all = 0; e_wl = 0; e_cs = 0; e_ds = 0;
      if (ph == PH_CONV && m_cyc < CMAX) m_cyc++;
      if (m_draining) begin
        if (drain_done) m_draining = 0;
      end else if (pq.size() > 0) begin
        m_dbank = pq.pop_front(); m_draining = 1; e_ds = 1;
      end
      case (ph)
        PH_IDLE: if (host_start && host_layers != 0) begin
          ph = PH_LOAD; m_layer = 0; m_last = int'(host_layers) - 1;
          m_cyc = 0; m_busy = 1; e_wl = 1;
        end
        PH_LOAD: if (wload_done) ph = PH_BANKWAIT;
        PH_BANKWAIT: if (free) begin ph = PH_CONV; e_cs = 1; end
        PH_CONV: if (conv_done) begin
          pq.push_back(m_layer % 2);
          if (m_layer == m_last) ph = PH_FLUSH;
          else begin m_layer++; ph = PH_LOAD; e_wl = 1; end
        end
        PH_FLUSH: if (quiet) begin ph = PH_IDLE; m_busy = 0; e_all = 1; end
        default: ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(m_busy));
    check("all_done", 32'(all_done), 32'(e_all));
    check("layer_idx", 32'(layer_idx), 32'(m_layer));
    check("wload_start", 32'(wload_start), 32'(e_wl));
    check("conv_start", 32'(conv_start), 32'(e_cs));
    check("conv_bank", 32'(conv_bank), 32'(m_layer % 2));
    check("drain_start", 32'(drain_start), 32'(e_ds));
    if (e_ds || m_draining) check("drain_bank", 32'(drain_bank), 32'(m_dbank));
    check("conv_cycles", 32'(conv_cycles), m_cyc);
  endtask

  task automatic clear_log();
    wl_cyc.delete(); cs_cyc.delete(); cd_cyc.delete(); dd_cyc.delete(); ad_cyc.delete();
    cs_bank.delete(); ds_bank.delete(); n_wl = 0; n_cs = 0; n_ds = 0; n_ad = 0;
  endtask

  // Advance one cycle: model consumes the held inputs, then sample, check and redrive at negedge
  task automatic tick();
    if (conv_done) cd_cyc.push_back(cycle);
    if (drain_done) dd_cyc.push_back(cycle);
    model_step();
    @(negedge clk);
    cycle++;
    host_start = 0; abort = 0; wload_done = 0; conv_done = 0; drain_done = 0;
    compare_all();
    if (wload_start) begin n_wl++; wl_cyc.push_back(cycle); end
    if (conv_start) begin n_cs++; cs_cyc.push_back(cycle); cs_bank.push_back(int'(conv_bank)); end
    if (drain_start) begin n_ds++; ds_bank.push_back(int'(drain_bank)); end
    if (all_done) begin n_ad++; ad_cyc.push_back(cycle); end
    if (auto_resp) begin
      if (wload_start) wl_cnt = dw;
      else if (wl_cnt > 0) begin wl_cnt--; if (wl_cnt == 0) wload_done = 1; end
      if (conv_start) cv_cnt = dc;
      else if (cv_cnt > 0) begin cv_cnt--; if (cv_cnt == 0) conv_done = 1; end
      if (drain_start) dr_cnt = dd;
      else if (dr_cnt > 0) begin dr_cnt--; if (dr_cnt == 0) drain_done = 1; end
      if (noise) begin
        if ($urandom_range(15) == 0) wload_done = 1;
        if ($urandom_range(15) == 0) conv_done = 1;
        if ($urandom_range(15) == 0) drain_done = 1;
      end
    end
  endtask

  task automatic wait_out(input int which, input int budget);
    logic ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (which == O_WL) ? wload_start : (which == O_CS) ? conv_start : drain_start;
    end
    check($sformatf("wait_out_%0d", which), 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (busy === 1'b0 && !m_busy) ok = 1;
    end
    check({name, "_ends"}, 32'(ok), 32'd1);
  endtask

  task automatic start_run(input int layers);
    host_layers = LW'(layers);
    host_start  = 1;
  endtask

  initial begin
    int abort_at;
    logic fin;
    rst = 1; host_start = 0; abort = 0; host_layers = '0;
    wload_done = 0; conv_done = 0; drain_done = 0;
    repeat (3) tick();
    rst = 0;
    check("rst_busy", 32'(busy), 0);
    check("rst_layer_idx", 32'(layer_idx), 0);
    check("rst_conv_cycles", 32'(conv_cycles), 0);
    check("rst_pulses", 32'({wload_start, conv_start, drain_start, all_done}), 0);
    check("rst_banks", 32'({conv_bank, drain_bank}), 0);
    tick();

    // Single layer, 5-cycle responders
    clear_log(); dw = 5; dc = 5; dd = 5;
    start_run(1);
    wait_idle("single", 300);
    check("single_n_wl", n_wl, 1);
    check("single_n_cs", n_cs, 1);
    check("single_n_ds", n_ds, 1);
    check("single_n_ad", n_ad, 1);
    check("single_cs_bank", cs_bank[0], 0);
    check("single_ds_bank", ds_bank[0], 0);
    check("single_ad_after_dd", ad_cyc[0], dd_cyc[0] + 1);
    check("single_conv_cycles", 32'(conv_cycles), 6);
    repeat (5) tick();
    check("single_busy_after", 32'(busy), 0);

    // Three layers, fast drain
    clear_log(); dw = 2; dc = 3; dd = 1;
    start_run(3);
    wait_idle("fast3", 300);
    check("fast3_cs_bank0", cs_bank[0], 0);
    check("fast3_cs_bank1", cs_bank[1], 1);
    check("fast3_cs_bank2", cs_bank[2], 0);
    check("fast3_ds_bank0", ds_bank[0], 0);
    check("fast3_ds_bank1", ds_bank[1], 1);
    check("fast3_ds_bank2", ds_bank[2], 0);
    check("fast3_wl1", wl_cyc[1], cd_cyc[0] + 1);
    check("fast3_wl2", wl_cyc[2], cd_cyc[1] + 1);
    check("fast3_conv_cycles", 32'(conv_cycles), 12);
    repeat (5) tick();

    // Three layers, slow drain holds layer 2 until bank 0 frees
    clear_log(); dw = 2; dc = 3; dd = 200;
    start_run(3);
    wait_idle("slow3", 2000);
    check("slow3_n_cs", n_cs, 3);
    check("slow3_cs2_after_dd0", cs_cyc[2], dd_cyc[0] + 2);
    check("slow3_cs1_not_blocked", 32'(cs_cyc[1] < dd_cyc[0]), 1);
    repeat (5) tick();

    // conv_done and drain_done in the same cycle
    clear_log(); auto_resp = 0;
    start_run(2);
    wait_out(O_WL, 20); wload_done = 1;
    wait_out(O_CS, 20); conv_done = 1;
    wait_out(O_WL, 20); wload_done = 1;
    wait_out(O_CS, 20); conv_done = 1; drain_done = 1;
    tick();
    check("simul_no_early_ds", 32'(drain_start), 0);
    tick();
    check("simul_ds", 32'(drain_start), 1);
    check("simul_ds_bank", 32'(drain_bank), 1);
    drain_done = 1;
    tick();
    check("simul_all_done", 32'(all_done), 1);
    check("simul_n_ds", n_ds, 2);
    auto_resp = 1;
    repeat (5) tick();

    // Abort mid-CONV_RUN of layer 1
    dw = 2; dc = 20; dd = 30;
    start_run(4);
    wait_out(O_CS, 50);
    wait_out(O_CS, 100);
    repeat (3) tick();
    abort = 1;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_layer_idx", 32'(layer_idx), 0);
    clear_log();
    repeat (40) tick();
    check("abort_no_all_done", n_ad, 0);
    check("abort_no_drain", n_ds, 0);
    check("abort_no_conv", n_cs, 0);
    start_run(4);
    tick();
    check("restart_layer_idx", 32'(layer_idx), 0);
    check("restart_wload_start", 32'(wload_start), 1);
    check("restart_conv_cycles", 32'(conv_cycles), 0);
    wait_idle("restart", 1000);
    check("restart_n_ad", n_ad, 1);
    check("restart_saturated", 32'(conv_cycles), CMAX);
    repeat (5) tick();

    // Ignored requests: zero layers, and start while busy
    clear_log();
    start_run(0);
    repeat (10) tick();
    check("zero_pulses", n_wl + n_cs + n_ds + n_ad, 0);
    check("zero_busy", 32'(busy), 0);
    check("zero_conv_cycles", 32'(conv_cycles), CMAX);
    dw = 2; dc = 4; dd = 3;
    start_run(2);
    repeat (3) tick();
    start_run(7);
    wait_idle("busy_start", 500);
    check("busy_start_n_cs", n_cs, 2);
    check("busy_start_n_ad", n_ad, 1);
    check("busy_start_conv_cycles", 32'(conv_cycles), 10);
    repeat (5) tick();

    // Randomized runs with stray done pulses, occasional aborts and busy restarts
    noise = 1;
    for (int r = 0; r < 25; r++) begin
      dw = $urandom_range(1, 8); dc = $urandom_range(1, 8); dd = $urandom_range(1, 40);
      abort_at = ($urandom_range(3) == 0) ? int'($urandom_range(2, 200)) : -1;
      start_run($urandom_range(1, 15));
      fin = 0;
      for (int i = 0; i < 3000 && !fin; i++) begin
        tick();
        if (i > 0 && busy === 1'b0 && !m_busy) fin = 1;
        else if (i == abort_at) abort = 1;
        else if ($urandom_range(63) == 0) begin
          host_layers = LW'($urandom_range(0, 15)); host_start = 1;
        end
      end
      check($sformatf("rand%0d_ends", r), 32'(fin), 1);
      repeat (30) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
